// File: rtl/tlul_dev_adapter.sv
// TL-UL device-side adapter: terminates the A/D channel pair onto an in-order
// req/gnt/rvalid memory port, with request legality checks and bounded outstanding.

module tlul_dev_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  cnt
);

  localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

module tlul_dev_adapter #(
  parameter int unsigned Outstanding = 2,
  parameter bit          ErrOnWrite  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [2:0]  a_opcode_i,
  input  logic [1:0]  a_size_i,
  input  logic [7:0]  a_source_i,
  input  logic [31:0] a_address_i,
  input  logic [3:0]  a_mask_i,
  input  logic [31:0] a_data_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [2:0]  d_opcode_o,
  output logic [1:0]  d_size_o,
  output logic [7:0]  d_source_o,
  output logic [31:0] d_data_o,
  output logic        d_error_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [29:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] wmask_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        rerror_i
);

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_op_e;

  typedef struct packed {
    logic       get;
    logic [1:0] size;
    logic [7:0] source;
    logic       err;
  } info_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rerror;
  } rsp_t;

  localparam int unsigned     CntW   = $clog2(Outstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(Outstanding);

  logic [3:0]      lanes;
  logic            misaligned;
  logic            is_put;
  logic            op_legal;
  logic            mask_err;
  logic            err;
  logic            space;
  logic            accept;
  logic            d_fire;
  logic            rsp_pop;
  info_t           info_in;
  info_t           info_head;
  rsp_t            rsp_in;
  rsp_t            rsp_head;
  logic [CntW-1:0] info_cnt;
  logic [CntW-1:0] rsp_cnt;

  always_comb begin
    lanes      = 4'b1111;
    misaligned = 1'b0;
    case (a_size_i)
      2'd0: lanes = 4'b0001 << a_address_i[1:0];
      2'd1: begin
        lanes      = a_address_i[1] ? 4'b1100 : 4'b0011;
        misaligned = a_address_i[0];
      end
      2'd2: misaligned = |a_address_i[1:0];
      default: ;
    endcase
    is_put   = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData);
    op_legal = is_put || (a_opcode_i == Get);
    mask_err = (|(a_mask_i & ~lanes)) ||
               ((a_opcode_i == PutFullData) && (a_mask_i != lanes));
    err      = !op_legal || (a_size_i == 2'd3) || misaligned || mask_err ||
               (is_put && ErrOnWrite);
  end

  // Outstanding count equals info FIFO occupancy: push on accept, pop on D handshake.
  assign space     = (info_cnt < MaxCnt);
  assign req_o     = a_valid_i & space & ~err;
  assign a_ready_o = space & (err | gnt_i);
  assign accept    = a_valid_i & a_ready_o;

  assign we_o    = is_put;
  assign addr_o  = a_address_i[31:2];
  assign wdata_o = a_data_i;

  always_comb begin
    wmask_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wmask_o[8*i +: 8] = {8{a_mask_i[i]}};
    end
  end

  assign info_in.get    = (a_opcode_i == Get);
  assign info_in.size   = a_size_i;
  assign info_in.source = a_source_i;
  assign info_in.err    = err;

  assign rsp_in.rdata  = rdata_i;
  assign rsp_in.rerror = rerror_i;

  tlul_dev_fifo #(
    .Width ($bits(info_t)),
    .Depth (Outstanding),
    .CntW  (CntW)
  ) u_info_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .wdata  (info_in),
    .pop    (d_fire),
    .rdata  (info_head),
    .cnt    (info_cnt)
  );

  tlul_dev_fifo #(
    .Width ($bits(rsp_t)),
    .Depth (Outstanding),
    .CntW  (CntW)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (rvalid_i),
    .wdata  (rsp_in),
    .pop    (rsp_pop),
    .rdata  (rsp_head),
    .cnt    (rsp_cnt)
  );

  // Errored heads own no memory response, so they retire without touching rsp.
  assign d_valid_o = (info_cnt != '0) && (info_head.err || (rsp_cnt != '0));
  assign d_fire    = d_valid_o & d_ready_i;
  assign rsp_pop   = d_fire & ~info_head.err;

  assign d_opcode_o = info_head.get ? AccessAckData : AccessAck;
  assign d_size_o   = info_head.size;
  assign d_source_o = info_head.source;
  assign d_data_o   = (info_head.get && !info_head.err) ? rsp_head.rdata : '0;
  assign d_error_o  = info_head.err || rsp_head.rerror;

endmodule

// File: tb/tb_tlul_dev_adapter.sv
// Self-checking bench for tlul_dev_adapter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based transaction model.

module tb_tlul_dev_adapter;

  localparam int unsigned OUT = 2;
  localparam bit          EOW = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready_o;
  logic [2:0]  a_opcode = 3'd4;
  logic [1:0]  a_size = 2'd2;
  logic [7:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = 4'hF;
  logic [31:0] a_data = '0;
  logic        d_valid_o;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [7:0]  d_source_o;
  logic [31:0] d_data_o;
  logic        d_error_o;
  logic        req_o;
  logic        gnt = 1'b0;
  logic        we_o;
  logic [29:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] wmask_o;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        rerror = 1'b0;

  always #5 clk = ~clk;

  tlul_dev_adapter #(
    .Outstanding (OUT),
    .ErrOnWrite  (EOW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .a_valid_i   (a_valid),
    .a_ready_o   (a_ready_o),
    .a_opcode_i  (a_opcode),
    .a_size_i    (a_size),
    .a_source_i  (a_source),
    .a_address_i (a_address),
    .a_mask_i    (a_mask),
    .a_data_i    (a_data),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready),
    .d_opcode_o  (d_opcode_o),
    .d_size_o    (d_size_o),
    .d_source_o  (d_source_o),
    .d_data_o    (d_data_o),
    .d_error_o   (d_error_o),
    .req_o       (req_o),
    .gnt_i       (gnt),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .wmask_o     (wmask_o),
    .rvalid_i    (rvalid),
    .rdata_i     (rdata),
    .rerror_i    (rerror)
  );

  typedef struct {
    bit         get;
    logic [1:0] size;
    logic [7:0] src;
    bit         err;
  } minfo_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
  } mrsp_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int unsigned due;
  } grant_t;

  minfo_t      info_q[$];
  mrsp_t       rsp_q[$];
  grant_t      grant_q[$];
  logic [31:0] mem_words [bit [29:0]];

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned mem_lat = 1;
  bit          rand_lat = 1'b0;
  bit          rand_rerr = 1'b0;
  bit          force_rerr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lanes covered by a naturally aligned container of 2^size bytes holding off.
  function automatic logic [3:0] addressed(input logic [1:0] size, input logic [1:0] off);
    int unsigned n;
    int unsigned lo;
    logic [3:0]  m;
    n  = 1 << size;
    lo = off - (off % n);
    m  = '0;
    for (int unsigned l = 0; l < 4; l++) m[l] = (l >= lo) && (l < lo + n);
    return m;
  endfunction

  function automatic bit model_err(input logic [2:0] op, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [3:0] mask);
    bit          e;
    int unsigned off;
    logic [3:0]  lanes;
    if (size > 2) return 1'b1;
    e     = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
    off   = addr[1:0];
    lanes = addressed(size, addr[1:0]);
    if ((off % (1 << size)) != 0) e = 1'b1;
    for (int unsigned l = 0; l < 4; l++) begin
      if (mask[l] && !lanes[l]) e = 1'b1;
      if (op == 3'd0 && mask[l] != lanes[l]) e = 1'b1;
    end
    if (EOW && (op == 3'd0 || op == 3'd1)) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] read_word(input bit [29:0] w);
    return mem_words.exists(w) ? mem_words[w] : ({2'b00, w} ^ 32'hC0DE_0000);
  endfunction

  // Memory responder: one in-order rvalid per grant, due cycles set at grant time.
  always @(posedge clk) begin
    cyc++;
    #1;
    rvalid = 1'b0;
    rerror = 1'b0;
    rdata  = $urandom;
    if (rst_n && grant_q.size() > 0 && grant_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = grant_q[0].data;
      rerror = grant_q[0].err;
      void'(grant_q.pop_front());
    end
  end

  bit          m_err;
  bit          m_space;
  bit          m_req;
  bit          m_rdy;
  bit          m_dv;
  minfo_t      m_head;
  minfo_t      m_new;
  mrsp_t       m_rsp;
  grant_t      m_gr;
  logic [31:0] m_wm;
  bit [29:0]   m_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      info_q.delete();
      rsp_q.delete();
      grant_q.delete();
      chk("d_valid_in_reset", d_valid_o, 0);
    end else begin
      m_err   = model_err(a_opcode, a_size, a_address, a_mask);
      m_space = info_q.size() < OUT;
      m_req   = a_valid && m_space && !m_err;
      m_rdy   = m_space && (m_err || gnt);
      chk("a_ready", a_ready_o, m_rdy);
      chk("req", req_o, m_req);
      for (int unsigned l = 0; l < 4; l++) m_wm[8*l +: 8] = a_mask[l] ? 8'hFF : 8'h00;
      if (a_valid) begin
        chk("we", we_o, (a_opcode == 3'd0 || a_opcode == 3'd1));
        chk("addr", addr_o, a_address >> 2);
        chk("wdata", wdata_o, a_data);
        chk("wmask", wmask_o, m_wm);
      end
      m_dv = info_q.size() > 0 && (info_q[0].err || rsp_q.size() > 0);
      chk("d_valid", d_valid_o, m_dv);
      if (m_dv) begin
        m_head = info_q[0];
        chk("d_opcode", d_opcode_o, m_head.get ? 1 : 0);
        chk("d_size", d_size_o, m_head.size);
        chk("d_source", d_source_o, m_head.src);
        if (m_head.err) begin
          chk("d_data", d_data_o, 0);
          chk("d_error", d_error_o, 1);
        end else begin
          chk("d_data", d_data_o, m_head.get ? rsp_q[0].data : 32'd0);
          chk("d_error", d_error_o, rsp_q[0].err);
        end
        if (d_ready) begin
          void'(info_q.pop_front());
          if (!m_head.err) void'(rsp_q.pop_front());
        end
      end
      if (rvalid) begin
        m_rsp.data = rdata;
        m_rsp.err  = rerror;
        rsp_q.push_back(m_rsp);
      end
      if (a_valid && m_rdy) begin
        m_new.get  = (a_opcode == 3'd4);
        m_new.size = a_size;
        m_new.src  = a_source;
        m_new.err  = m_err;
        info_q.push_back(m_new);
      end
      if (m_req && gnt) begin
        m_w = a_address[31:2];
        if (a_opcode != 3'd4) mem_words[m_w] = (read_word(m_w) & ~m_wm) | (a_data & m_wm);
        m_gr.data = read_word(m_w);
        m_gr.err  = force_rerr || (rand_rerr && $urandom_range(0, 9) == 0);
        m_gr.due  = cyc + (rand_lat ? $urandom_range(1, 4) : mem_lat);
        grant_q.push_back(m_gr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                      input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] sr,
                      output logic req_s, output logic we_s, output logic [31:0] wm_s);
    bit acc;
    acc       = 1'b0;
    req_s     = 1'b0;
    we_s      = 1'b0;
    wm_s      = '0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = sz;
    a_address = ad;
    a_mask    = mk;
    a_data    = dt;
    a_source  = sr;
    for (int unsigned i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (a_ready_o) begin
        acc   = 1'b1;
        req_s = req_o;
        we_s  = we_o;
        wm_s  = wmask_o;
      end
      tick();
    end
    a_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic get_d(input string tag, output int unsigned waited, output logic [2:0] op,
                       output logic [7:0] src, output logic [31:0] data, output logic err);
    bit got;
    got    = 1'b0;
    waited = 0;
    op     = 'x;
    src    = 'x;
    data   = 'x;
    err    = 'x;
    for (int unsigned i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (d_valid_o) begin
        got  = 1'b1;
        op   = d_opcode_o;
        src  = d_source_o;
        data = d_data_o;
        err  = d_error_o;
      end else begin
        waited++;
      end
      tick();
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic rand_req();
    int unsigned r;
    int unsigned v;
    logic [3:0]  lanes;
    r = $urandom_range(0, 9);
    if (r < 4 || r == 9) a_opcode = 3'd4;
    else if (r < 6)      a_opcode = 3'd0;
    else if (r < 8)      a_opcode = 3'd1;
    else begin
      v        = $urandom_range(0, 4);
      a_opcode = (v < 2) ? 3'(v + 2) : 3'(v + 3);
    end
    a_size    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a_address = 32'($urandom_range(0, 1023));
    if (a_size != 2'd3 && $urandom_range(0, 9) < 8)
      a_address = a_address & ~(32'(1 << a_size) - 32'd1);
    lanes = (a_size != 2'd3) ? addressed(a_size, a_address[1:0]) : 4'hF;
    if ($urandom_range(0, 9) == 0) a_mask = 4'($urandom);
    else if (a_opcode == 3'd0)     a_mask = lanes;
    else                           a_mask = lanes & 4'($urandom);
    a_data   = $urandom;
    a_source = 8'($urandom);
    a_valid  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic        s_req;
  logic        s_we;
  logic [31:0] s_wm;
  int unsigned w;
  logic [2:0]  r_op;
  logic [7:0]  r_src;
  logic [31:0] r_data;
  logic        r_err;
  bit          acc_last;

  initial begin
    mem_words[30'h40] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_d_valid", d_valid_o, 0);
    chk("reset_req", req_o, 0);
    chk("reset_a_ready_no_gnt", a_ready_o, 0);
    tick();
    gnt = 1'b1;
    @(negedge clk);
    chk("reset_a_ready_gnt", a_ready_o, 1);
    tick();

    // Aligned word read, one-cycle memory latency.
    send(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'h11, s_req, s_we, s_wm);
    chk("t1_req", s_req, 1);
    get_d("t1", w, r_op, r_src, r_data, r_err);
    chk("t1_latency", w, 1);
    chk("t1_opcode", r_op, 1);
    chk("t1_data", r_data, 32'hDEADBEEF);
    chk("t1_source", r_src, 8'h11);
    chk("t1_error", r_err, 0);

    // Upper half-word partial write.
    send(3'd1, 2'd1, 32'h102, 4'hC, 32'hAABB0000, 8'h22, s_req, s_we, s_wm);
    chk("t2_req", s_req, 1);
    chk("t2_we", s_we, 1);
    chk("t2_wmask", s_wm, 32'hFFFF0000);
    get_d("t2", w, r_op, r_src, r_data, r_err);
    chk("t2_opcode", r_op, 0);
    chk("t2_data", r_data, 0);
    chk("t2_source", r_src, 8'h22);
    chk("t2_error", r_err, 0);

    // Misaligned word read: never reaches memory, errors the next cycle.
    send(3'd4, 2'd2, 32'h101, 4'hF, 32'h0, 8'h33, s_req, s_we, s_wm);
    chk("t3_req", s_req, 0);
    get_d("t3", w, r_op, r_src, r_data, r_err);
    chk("t3_latency", w, 0);
    chk("t3_opcode", r_op, 1);
    chk("t3_data", r_data, 0);
    chk("t3_error", r_err, 1);

    // Back-to-back Gets with D stalled: the third waits for a pop.
    d_ready   = 1'b0;
    a_valid   = 1'b1;
    a_opcode  = 3'd4;
    a_size    = 2'd2;
    a_address = 32'h100;
    a_mask    = 4'hF;
    a_source  = 8'h40;
    @(negedge clk); chk("t4_ready_first", a_ready_o, 1); tick();
    a_source = 8'h41;
    @(negedge clk); chk("t4_ready_second", a_ready_o, 1); tick();
    a_source = 8'h42;
    @(negedge clk); chk("t4_ready_third_full", a_ready_o, 0); tick();
    @(negedge clk);
    chk("t4_hold_full", a_ready_o, 0);
    chk("t4_d_valid", d_valid_o, 1);
    chk("t4_head_source", d_source_o, 8'h40);
    tick();
    d_ready = 1'b1;
    @(negedge clk); chk("t4_no_skid", a_ready_o, 0); tick();
    @(negedge clk);
    chk("t4_freed", a_ready_o, 1);
    chk("t4_second_source", d_source_o, 8'h41);
    tick();
    a_valid = 1'b0;
    get_d("t4", w, r_op, r_src, r_data, r_err);
    chk("t4_third_source", r_src, 8'h42);
    chk("t4_third_data", r_data, 32'hAABBBEEF);

    // Slow read followed by an illegal opcode: errors wait their turn.
    mem_lat = 3;
    send(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'h50, s_req, s_we, s_wm);
    send(3'd3, 2'd2, 32'h104, 4'hF, 32'h0, 8'h51, s_req, s_we, s_wm);
    chk("t5_illegal_req", s_req, 0);
    get_d("t5a", w, r_op, r_src, r_data, r_err);
    chk("t5_first_source", r_src, 8'h50);
    chk("t5_first_opcode", r_op, 1);
    chk("t5_first_data", r_data, 32'hAABBBEEF);
    chk("t5_first_error", r_err, 0);
    get_d("t5b", w, r_op, r_src, r_data, r_err);
    chk("t5_second_source", r_src, 8'h51);
    chk("t5_second_opcode", r_op, 0);
    chk("t5_second_error", r_err, 1);

    // Memory error on a write.
    mem_lat    = 1;
    force_rerr = 1'b1;
    send(3'd0, 2'd2, 32'h200, 4'hF, 32'h12345678, 8'h60, s_req, s_we, s_wm);
    force_rerr = 1'b0;
    get_d("t6", w, r_op, r_src, r_data, r_err);
    chk("t6_opcode", r_op, 0);
    chk("t6_error", r_err, 1);
    chk("t6_data", r_data, 0);

    // Reset with two transactions pending.
    d_ready = 1'b0;
    send(3'd4, 2'd2, 32'h104, 4'hF, 32'h0, 8'h70, s_req, s_we, s_wm);
    send(3'd4, 2'd2, 32'h108, 4'hF, 32'h0, 8'h71, s_req, s_we, s_wm);
    tick();
    tick();
    @(negedge clk);
    chk("t7_full_a_ready", a_ready_o, 0);
    chk("t7_pending_d_valid", d_valid_o, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk); chk("t7_reset_d_valid", d_valid_o, 0); tick();
    rst_n   = 1'b1;
    d_ready = 1'b1;
    @(negedge clk); chk("t7_count_cleared", a_ready_o, 1);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t7_no_stale_response", d_valid_o, 0);
    end
    tick();

    // Randomized traffic; A held stable until accepted.
    rand_lat  = 1'b1;
    rand_rerr = 1'b1;
    acc_last  = 1'b0;
    for (int unsigned n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n   = 1'b0;
        a_valid = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        acc_last = 1'b0;
      end
      if (!a_valid || acc_last) begin
        if ($urandom_range(0, 9) < 6) rand_req();
        else a_valid = 1'b0;
      end
      gnt     = ($urandom_range(0, 9) < 7);
      d_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc_last = a_valid && a_ready_o;
      tick();
    end

    a_valid  = 1'b0;
    a_opcode = 3'd4;
    a_size   = 2'd2;
    a_mask   = 4'hF;
    a_address = 32'h0;
    gnt      = 1'b1;
    d_ready  = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("drain_d_valid", d_valid_o, 0);
    chk("drain_a_ready", a_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
